seq_addsub_unit: RTL and testbench

//  Parametrised multi-cycle adder/subtractor for the calculator datapath.

---
 rtl/seq_addsub_pkg.sv | 14 +
 rtl/seq_addsub_unit_slice.sv | 46 ++++
 rtl/seq_addsub_unit.sv | 171 +++++++++++++++++
 tb/tb_seq_addsub_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_pkg.sv
// Shared constants for the multi-cycle adder/subtractor: operation codes
// and the 2-bit state encoding used by the sequencer.
package seq_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/seq_addsub_unit_slice.sv
// Combinational CHUNK-bit ripple adder built from a chain of full-adder cells.
// One slice is evaluated per clock by the sequential adder/subtractor.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module addsub_slice #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // carry[0] is the slice carry-in; carry[CHUNK] leaves the slice
  logic [CHUNK:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[CHUNK];

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_bit
      full_adder_cell u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .s    (s[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle unsigned adder/subtractor. Operands are captured on an accepted
// start, then CHUNK bits are summed per clock through one shared slice.
// Subtraction is done as opA + ~opB + 1 with the operands pre-swapped so the
// result is always the magnitude; the sign is reported separately on neg.
module seq_addsub_unit
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CHUNK     = 1,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 cout,
  output logic                 neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t               state_q,   state_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [OUT_WIDTH-1:0] result_q,  result_d;
  logic                 cout_q,    cout_d;
  logic                 neg_q,     neg_d;
  logic                 op_q,      op_d;
  logic                 neg_lat_q, neg_lat_d;
  logic                 carry_q,   carry_d;
  logic [WIDTH-1:0]     opa_q,     opa_d;
  logic [WIDTH-1:0]     opb_q,     opb_d;
  logic [WIDTH-1:0]     sum_q,     sum_d;
  logic [IDX_W-1:0]     idx_q,     idx_d;

  logic [CHUNK-1:0]     slice_a;
  logic [CHUNK-1:0]     slice_b;
  logic [CHUNK-1:0]     slice_s;
  logic                 slice_cout;

  assign slice_a = opa_q[int'(idx_q) * CHUNK +: CHUNK];
  assign slice_b = opb_q[int'(idx_q) * CHUNK +: CHUNK];

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Next-state logic: accept/swap operands, step one slice per CALC cycle,
  // publish result/cout/neg together with the done pulse
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    cout_d    = cout_q;
    neg_d     = neg_q;
    op_d      = op_q;
    neg_lat_d = neg_lat_q;
    carry_d   = carry_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    idx_d     = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          busy_d  = 1'b1;
          op_d    = op;
          idx_d   = '0;
          if (op == OP_ADD) begin
            opa_d     = a;
            opb_d     = b;
            carry_d   = 1'b0;
            neg_lat_d = 1'b0;
          end else if (a >= b) begin
            opa_d     = a;
            opb_d     = ~b;
            carry_d   = 1'b1;
            neg_lat_d = 1'b0;
          end else begin
            // swap so the subtraction never underflows
            opa_d     = b;
            opb_d     = ~a;
            carry_d   = 1'b1;
            neg_lat_d = 1'b1;
          end
        end
      end

      ST_CALC: begin
        sum_d[int'(idx_q) * CHUNK +: CHUNK] = slice_s;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d            = ST_DONE;
          done_d             = 1'b1;
          idx_d              = '0;
          result_d           = '0;
          result_d[WIDTH-1:0] = sum_d;
          // the final carry of a subtraction is only the two's-complement artefact
          cout_d             = (op_q == OP_ADD) ? slice_cout : 1'b0;
          result_d[WIDTH]    = cout_d;
          neg_d              = neg_lat_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation and clears outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      neg_q     <= 1'b0;
      op_q      <= OP_ADD;
      neg_lat_q <= 1'b0;
      carry_q   <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      neg_q     <= neg_d;
      op_q      <= op_d;
      neg_lat_q <= neg_lat_d;
      carry_q   <= carry_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign neg    = neg_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed bench for seq_addsub_unit: a bit-serial 4-bit instance and an
// 8-bit instance summing 4 bits per clock.
module tb_seq_addsub_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0;
  logic        op4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        busy4, done4, cout4, neg4;
  logic [7:0]  result4;

  logic        start8 = 1'b0;
  logic        op8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, cout8, neg8;
  logic [11:0] result8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_addsub_unit #(.WIDTH(4), .CHUNK(1), .OUT_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .neg(neg4)
  );

  seq_addsub_unit #(.WIDTH(8), .CHUNK(4), .OUT_WIDTH(12)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .neg(neg8)
  );

  // Drives one 4-bit operation from idle; returns edges from accept to done
  // (accept edge counts as 1) and then steps past the DONE cycle.
  task automatic run4(input logic o, input logic [3:0] x, input logic [3:0] y,
                      output int cycles, output bit timed_out);
    op4 = o; a4 = x; b4 = y; start4 = 1'b1;
    cycles = 0; timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      cycles++;
      if (done4) begin
        timed_out = 1'b0;
        break;
      end
    end
    $display("[TB] w4 op=%0d a=%0d b=%0d -> result=0x%0h cout=%0b neg=%0b cycles=%0d",
             o, x, y, result4, cout4, neg4, cycles);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
    n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4 got=%b exp=0", done4); end
    n_tests++; if (result4 !== 8'h00) begin n_fail++; $display("FAIL reset_result4 got=%h exp=00", result4); end
    n_tests++; if (cout4 !== 1'b0) begin n_fail++; $display("FAIL reset_cout4 got=%b exp=0", cout4); end
    n_tests++; if (neg4 !== 1'b0) begin n_fail++; $display("FAIL reset_neg4 got=%b exp=0", neg4); end
    n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    n_tests++; if (result8 !== 12'h000) begin n_fail++; $display("FAIL reset_result8 got=%h exp=000", result8); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset released");
  endtask

  task automatic test_add();
    int cyc;
    bit to;
    logic [3:0] va [4] = '{4'd15, 4'd1, 4'd15, 4'd0};
    logic [3:0] vb [4] = '{4'd15, 4'd2, 4'd1,  4'd0};
    logic [7:0] vr [4] = '{8'h1E, 8'h03, 8'h10, 8'h00};
    logic       vc [4] = '{1'b1,  1'b0,  1'b1,  1'b0};
    run4(1'b0, 4'd9, 4'd8, cyc, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL add9p8_timeout no done within 20 cycles"); end
    n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL add9p8_latency got=%0d exp=5", cyc); end
    n_tests++; if (result4 !== 8'h11) begin n_fail++; $display("FAIL add9p8_result got=%h exp=11", result4); end
    n_tests++; if (cout4 !== 1'b1) begin n_fail++; $display("FAIL add9p8_cout got=%b exp=1", cout4); end
    n_tests++; if (neg4 !== 1'b0) begin n_fail++; $display("FAIL add9p8_neg got=%b exp=0", neg4); end
    for (int i = 0; i < 4; i++) begin
      run4(1'b0, va[i], vb[i], cyc, to);
      n_tests++; if (result4 !== vr[i]) begin n_fail++; $display("FAIL add_vec%0d_result got=%h exp=%h", i, result4, vr[i]); end
      n_tests++; if (cout4 !== vc[i]) begin n_fail++; $display("FAIL add_vec%0d_cout got=%b exp=%b", i, cout4, vc[i]); end
    end
  endtask

  task automatic test_sub();
    int cyc;
    bit to;
    logic [3:0] va [5] = '{4'd3,  4'd7,  4'd5,  4'd0,  4'd15};
    logic [3:0] vb [5] = '{4'd7,  4'd3,  4'd5,  4'd15, 4'd0};
    logic [7:0] vr [5] = '{8'h04, 8'h04, 8'h00, 8'h0F, 8'h0F};
    logic       vn [5] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    for (int i = 0; i < 5; i++) begin
      run4(1'b1, va[i], vb[i], cyc, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL sub_vec%0d_timeout no done", i); end
      n_tests++; if (result4 !== vr[i]) begin n_fail++; $display("FAIL sub_vec%0d_result got=%h exp=%h", i, result4, vr[i]); end
      n_tests++; if (neg4 !== vn[i]) begin n_fail++; $display("FAIL sub_vec%0d_neg got=%b exp=%b", i, neg4, vn[i]); end
      n_tests++; if (cout4 !== 1'b0) begin n_fail++; $display("FAIL sub_vec%0d_cout got=%b exp=0", i, cout4); end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    int extra_done;
    bit seen;
    op4 = 1'b0; a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept got=%b exp=1", busy4); end
    @(posedge clk); #1;
    a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 3; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done4) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    $display("[TB] w4 busy-drop add 2+3 -> result=0x%0h cycles=%0d", result4, cyc);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL busy_drop_timeout no done"); end
    n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL busy_drop_latency got=%0d exp=5", cyc); end
    n_tests++; if (result4 !== 8'h05) begin n_fail++; $display("FAIL busy_drop_result got=%h exp=05", result4); end
    n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL busy_in_done_cycle got=%b exp=1", busy4); end
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done4) extra_done++;
    end
    n_tests++; if (extra_done != 0) begin n_fail++; $display("FAIL busy_drop_extra_done got=%0d exp=0", extra_done); end
  endtask

  task automatic test_done_cycle_start();
    int extra_done;
    op4 = 1'b0; a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done4) break;
      @(posedge clk); #1;
    end
    n_tests++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL donecyc_timeout no done"); end
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    $display("[TB] w4 start in DONE cycle -> busy=%0b result=0x%0h", busy4, result4);
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL donecyc_start_busy got=%b exp=0", busy4); end
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) extra_done++;
    end
    n_tests++; if (extra_done != 0) begin n_fail++; $display("FAIL donecyc_extra_done got=%0d exp=0", extra_done); end
    n_tests++; if (result4 !== 8'h04) begin n_fail++; $display("FAIL donecyc_result_hold got=%h exp=04", result4); end
  endtask

  task automatic test_operand_change();
    bit seen;
    op4 = 1'b0; a4 = 4'd6; b4 = 4'd1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'd15; b4 = 4'd15; op4 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done4) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    $display("[TB] w4 add 6+1 with operand change -> result=0x%0h cout=%0b", result4, cout4);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL opchg_timeout no done"); end
    n_tests++; if (result4 !== 8'h07) begin n_fail++; $display("FAIL opchg_result got=%h exp=07", result4); end
    n_tests++; if (cout4 !== 1'b0) begin n_fail++; $display("FAIL opchg_cout got=%b exp=0", cout4); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    int extra_done;
    run4(1'b1, 4'd3, 4'd7, cyc, to);
    n_tests++; if (neg4 !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_neg got=%b exp=1", neg4); end
    op4 = 1'b0; a4 = 4'd4; b4 = 4'd4; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] w4 reset mid-CALC -> busy=%0b result=0x%0h", busy4, result4);
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy4); end
    n_tests++; if (result4 !== 8'h00) begin n_fail++; $display("FAIL rstmid_result got=%h exp=00", result4); end
    n_tests++; if (neg4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_neg got=%b exp=0", neg4); end
    @(posedge clk); #1;
    rst = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) extra_done++;
    end
    n_tests++; if (extra_done != 0) begin n_fail++; $display("FAIL rstmid_done_after_abort got=%0d exp=0", extra_done); end
    run4(1'b0, 4'd1, 4'd1, cyc, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rstmid_next_timeout no done"); end
    n_tests++; if (result4 !== 8'h02) begin n_fail++; $display("FAIL rstmid_next_result got=%h exp=02", result4); end
  endtask

  task automatic test_wide();
    int cyc;
    bit seen;
    op8 = 1'b0; a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc++;
      if (done8) begin seen = 1'b1; break; end
    end
    $display("[TB] w8 add 200+100 -> result=0x%0h cout=%0b cycles=%0d", result8, cout8, cyc);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL wide_timeout no done"); end
    n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL wide_latency got=%0d exp=3", cyc); end
    n_tests++; if (result8 !== 12'h12C) begin n_fail++; $display("FAIL wide_result got=%h exp=12c", result8); end
    n_tests++; if (cout8 !== 1'b1) begin n_fail++; $display("FAIL wide_cout got=%b exp=1", cout8); end
    @(posedge clk); #1;
    op8 = 1'b1; a8 = 8'd10; b8 = 8'd200; start8 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done8) begin seen = 1'b1; break; end
    end
    $display("[TB] w8 sub 10-200 -> result=0x%0h neg=%0b", result8, neg8);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL wide_sub_timeout no done"); end
    n_tests++; if (result8 !== 12'h0BE) begin n_fail++; $display("FAIL wide_sub_result got=%h exp=0be", result8); end
    n_tests++; if (neg8 !== 1'b1) begin n_fail++; $display("FAIL wide_sub_neg got=%b exp=1", neg8); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_busy_ignore();
    test_done_cycle_start();
    test_operand_change();
    test_reset_mid();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
